// File: rtl/rtp_audio_depacketizer.sv
// RTP audio receive path: parses the UDP byte stream, validates the RTP header and
// buffers big-endian 16-bit PCM samples in a jitter FIFO that feeds the codec playback port.
module rtp_audio_depacketizer #(
  parameter logic [15:0] RTP_Header_Param = 16'h8080,
  parameter logic [31:0] SSRC             = 32'h12345678,
  parameter bit          CHECK_SSRC       = 1'b1,
  parameter int          FIFO_AW          = 10,
  parameter int          START_LEVEL      = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               udp_rec_data_valid,
  input  logic [7:0]         udp_rec_rdata,
  input  logic [15:0]        udp_rec_data_length,
  input  logic               wav_rden,
  output logic [15:0]        wav_out_data,
  output logic               playing,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        last_seq,
  output logic [15:0]        pkt_ok_cnt,
  output logic [15:0]        pkt_err_cnt,
  output logic [15:0]        seq_gap_cnt,
  output logic [15:0]        ovf_cnt,
  output logic [15:0]        unf_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL  = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0] START_LVL = START_LEVEL[FIFO_AW:0];

  typedef enum logic [2:0] {
    P_WAIT_GAP,
    P_IDLE,
    P_HDR,
    P_PAYLOAD,
    P_DROP
  } pstate_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  pstate_t       pstate_q;
  logic [15:0]   bc_q;
  logic [15:0]   seq_q;
  logic [7:0]    msb_q;
  logic          have_seq_q;
  logic [15:0]   last_seq_q;
  logic [15:0]   ok_cnt_q, err_cnt_q, gap_cnt_q, ovf_cnt_q, unf_cnt_q;

  logic [15:0]   cur_bc;
  logic          byte_ok;
  logic          len_ok;
  logic          push_en;
  logic [15:0]   push_data;

  // In IDLE the arriving byte is header byte 0 even though bc_q has not moved yet.
  always_comb begin
    cur_bc  = (pstate_q == P_IDLE) ? 16'd0 : bc_q;
    byte_ok = 1'b1;
    case (cur_bc)
      16'd0:  byte_ok = (udp_rec_rdata == RTP_Header_Param[15:8]);
      16'd1:  byte_ok = (udp_rec_rdata[6:0] == RTP_Header_Param[6:0]);
      16'd8:  byte_ok = !CHECK_SSRC || (udp_rec_rdata == SSRC[31:24]);
      16'd9:  byte_ok = !CHECK_SSRC || (udp_rec_rdata == SSRC[23:16]);
      16'd10: byte_ok = !CHECK_SSRC || (udp_rec_rdata == SSRC[15:8]);
      16'd11: byte_ok = !CHECK_SSRC || (udp_rec_rdata == SSRC[7:0]);
      default: byte_ok = 1'b1;
    endcase
    len_ok    = (udp_rec_data_length >= 16'd12);
    push_en   = (pstate_q == P_PAYLOAD) && udp_rec_data_valid &&
                (bc_q < udp_rec_data_length) && bc_q[0];
    push_data = {msb_q, udp_rec_rdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate_q   <= P_WAIT_GAP;
      bc_q       <= 16'd0;
      seq_q      <= 16'd0;
      msb_q      <= 8'd0;
      have_seq_q <= 1'b0;
      last_seq_q <= 16'd0;
      ok_cnt_q   <= 16'd0;
      err_cnt_q  <= 16'd0;
      gap_cnt_q  <= 16'd0;
    end else begin
      case (pstate_q)
        P_WAIT_GAP: begin
          if (!udp_rec_data_valid) pstate_q <= P_IDLE;
        end
        P_IDLE: begin
          bc_q <= 16'd0;
          if (udp_rec_data_valid) begin
            bc_q <= 16'd1;
            if (!byte_ok || !len_ok) begin
              pstate_q  <= P_DROP;
              err_cnt_q <= sat_inc(err_cnt_q);
            end else begin
              pstate_q <= P_HDR;
            end
          end
        end
        P_HDR: begin
          if (!udp_rec_data_valid) begin
            pstate_q  <= P_IDLE;
            err_cnt_q <= sat_inc(err_cnt_q);
          end else begin
            bc_q <= bc_q + 16'd1;
            if (bc_q == 16'd2) seq_q[15:8] <= udp_rec_rdata;
            if (bc_q == 16'd3) seq_q[7:0]  <= udp_rec_rdata;
            if (!byte_ok) begin
              pstate_q  <= P_DROP;
              err_cnt_q <= sat_inc(err_cnt_q);
            end else if (bc_q == 16'd11) begin
              pstate_q   <= P_PAYLOAD;
              ok_cnt_q   <= sat_inc(ok_cnt_q);
              last_seq_q <= seq_q;
              have_seq_q <= 1'b1;
              if (have_seq_q && (seq_q != last_seq_q + 16'd1))
                gap_cnt_q <= sat_inc(gap_cnt_q);
            end
          end
        end
        P_PAYLOAD: begin
          if (!udp_rec_data_valid) begin
            pstate_q <= P_IDLE;
          end else begin
            if (bc_q != 16'hFFFF) bc_q <= bc_q + 16'd1;
            if (!bc_q[0]) msb_q <= udp_rec_rdata;
          end
        end
        P_DROP: begin
          if (!udp_rec_data_valid) pstate_q <= P_IDLE;
        end
        default: pstate_q <= P_WAIT_GAP;
      endcase
    end
  end

  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q;
  logic               play_q;
  logic [15:0]        out_q;
  logic               full, empty, wr_ok, rd_ok;

  // Full/empty come from the registered level, so a same-cycle pop never frees room for a push.
  always_comb begin
    full  = (level_q == FULL_LVL);
    empty = (level_q == '0);
    wr_ok = push_en && !full;
    rd_ok = wav_rden && play_q && !empty;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      play_q    <= 1'b0;
      out_q     <= 16'd0;
      ovf_cnt_q <= 16'd0;
      unf_cnt_q <= 16'd0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (push_en && full) ovf_cnt_q <= sat_inc(ovf_cnt_q);
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (!play_q) begin
        if (level_q >= START_LVL) play_q <= 1'b1;
        if (wav_rden) out_q <= 16'd0;
      end else if (wav_rden) begin
        if (empty) begin
          out_q     <= 16'd0;
          unf_cnt_q <= sat_inc(unf_cnt_q);
          play_q    <= 1'b0;
        end else begin
          out_q    <= mem[rd_ptr_q];
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  assign wav_out_data = out_q;
  assign playing      = play_q;
  assign fifo_level   = level_q;
  assign last_seq     = last_seq_q;
  assign pkt_ok_cnt   = ok_cnt_q;
  assign pkt_err_cnt  = err_cnt_q;
  assign seq_gap_cnt  = gap_cnt_q;
  assign ovf_cnt      = ovf_cnt_q;
  assign unf_cnt      = unf_cnt_q;

endmodule

// File: tb/tb_rtp_audio_depacketizer.sv
// Directed bench: a full-size instance for parsing/playback and a 16-deep instance
// for overflow/underflow, driven from a shared byte bus with per-instance valids.
module tb_rtp_audio_depacketizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_a, valid_b, rden_a, rden_b;
  logic [7:0]  rdata;
  logic [15:0] length;

  logic [15:0] out_a, out_b, seq_a, seq_b;
  logic        play_a, play_b;
  logic [10:0] lvl_a;
  logic [4:0]  lvl_b;
  logic [15:0] ok_a, err_a, gap_a, ovf_a, unf_a;
  logic [15:0] ok_b, err_b, gap_b, ovf_b, unf_b;

  logic [7:0]  pkt [0:1023];
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #10 clk = ~clk;

  rtp_audio_depacketizer dut_a (
    .clk(clk), .rst(rst),
    .udp_rec_data_valid(valid_a), .udp_rec_rdata(rdata), .udp_rec_data_length(length),
    .wav_rden(rden_a), .wav_out_data(out_a), .playing(play_a), .fifo_level(lvl_a),
    .last_seq(seq_a), .pkt_ok_cnt(ok_a), .pkt_err_cnt(err_a), .seq_gap_cnt(gap_a),
    .ovf_cnt(ovf_a), .unf_cnt(unf_a)
  );

  rtp_audio_depacketizer #(.FIFO_AW(4), .START_LEVEL(8)) dut_b (
    .clk(clk), .rst(rst),
    .udp_rec_data_valid(valid_b), .udp_rec_rdata(rdata), .udp_rec_data_length(length),
    .wav_rden(rden_b), .wav_out_data(out_b), .playing(play_b), .fifo_level(lvl_b),
    .last_seq(seq_b), .pkt_ok_cnt(ok_b), .pkt_err_cnt(err_b), .seq_gap_cnt(gap_b),
    .ovf_cnt(ovf_b), .unf_cnt(unf_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_hdr(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [15:0] seq, input logic [31:0] ssrc);
    pkt[0]  = b0;         pkt[1]  = b1;
    pkt[2]  = seq[15:8];  pkt[3]  = seq[7:0];
    pkt[4]  = 8'h00;      pkt[5]  = 8'h00; pkt[6] = 8'h00; pkt[7] = 8'h00;
    pkt[8]  = ssrc[31:24]; pkt[9]  = ssrc[23:16];
    pkt[10] = ssrc[15:8];  pkt[11] = ssrc[7:0];
  endtask

  task automatic send_run(input bit to_b, input int nbytes, input logic [15:0] len_field);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      if (to_b) valid_b = 1'b1; else valid_a = 1'b1;
      rdata  = pkt[i];
      length = len_field;
    end
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_rden(input bit to_b);
    @(negedge clk);
    if (to_b) rden_b = 1'b1; else rden_a = 1'b1;
    @(negedge clk);
    rden_a = 1'b0;
    rden_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
    rdata = 8'h00; length = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_eq("rst_out", out_a, 0);
    check_eq("rst_play", play_a, 0);
    check_eq("rst_level", lvl_a, 0);
    check_eq("rst_cnts", {ok_a, err_a}, 0);
    check_eq("rst_seq_gap", {seq_a, gap_a}, 0);
    check_eq("rst_ovf_unf", {ovf_a, unf_a}, 0);

    // Good packet, seq 5, 480 samples; first samples 1234 / ABCD
    set_hdr(8'h80, 8'h00, 16'd5, 32'h12345678);
    pkt[12] = 8'h12; pkt[13] = 8'h34; pkt[14] = 8'hAB; pkt[15] = 8'hCD;
    for (int i = 16; i < 972; i++) pkt[i] = i[7:0];
    send_run(1'b0, 972, 16'd972);
    check_eq("t1_ok", ok_a, 1);
    check_eq("t1_err", err_a, 0);
    check_eq("t1_seq", seq_a, 5);
    check_eq("t1_level", lvl_a, 480);
    check_eq("t1_play", play_a, 1);

    // Byte order and one-cycle read latency
    @(negedge clk);
    rden_a = 1'b1;
    check_eq("t2_pre", out_a, 16'h0000);
    @(negedge clk);
    rden_a = 1'b0;
    check_eq("t2_s0", out_a, 16'h1234);
    pulse_rden(1'b0);
    check_eq("t2_s1", out_a, 16'hABCD);
    repeat (3) @(negedge clk);
    check_eq("t2_hold", out_a, 16'hABCD);
    check_eq("t2_level", lvl_a, 478);

    // Header errors
    set_hdr(8'h90, 8'h00, 16'd7, 32'h12345678);
    send_run(1'b0, 972, 16'd972);
    check_eq("t3_b0_err", err_a, 1);
    check_eq("t3_b0_level", lvl_a, 478);
    set_hdr(8'h80, 8'h00, 16'd7, 32'hDEADBEEF);
    send_run(1'b0, 972, 16'd972);
    check_eq("t3_ssrc_err", err_a, 2);
    check_eq("t3_ssrc_level", lvl_a, 478);
    check_eq("t3_ssrc_seq", seq_a, 5);
    set_hdr(8'h80, 8'h00, 16'd7, 32'h12345678);
    send_run(1'b0, 8, 16'd8);
    check_eq("t3_len8_err", err_a, 3);
    send_run(1'b0, 6, 16'd972);
    check_eq("t3_short_err", err_a, 4);
    check_eq("t3_ok", ok_a, 1);

    // Sequence handling (marker bit set on seq 6 must be ignored)
    set_hdr(8'h80, 8'h80, 16'd6, 32'h12345678);
    send_run(1'b0, 16, 16'd16);
    check_eq("t4_s6_ok", ok_a, 2);
    check_eq("t4_s6_gap", gap_a, 0);
    check_eq("t4_s6_level", lvl_a, 480);
    set_hdr(8'h80, 8'h00, 16'd9, 32'h12345678);
    send_run(1'b0, 16, 16'd16);
    check_eq("t4_s9_gap", gap_a, 1);
    check_eq("t4_s9_seq", seq_a, 9);
    set_hdr(8'h80, 8'h00, 16'hFFFF, 32'h12345678);
    send_run(1'b0, 16, 16'd16);
    check_eq("t4_sffff_gap", gap_a, 2);
    set_hdr(8'h80, 8'h00, 16'h0000, 32'h12345678);
    send_run(1'b0, 16, 16'd16);
    check_eq("t4_wrap_gap", gap_a, 2);
    check_eq("t4_wrap_seq", seq_a, 0);
    check_eq("t4_wrap_level", lvl_a, 486);
    // 21-byte run, length 17: two samples, odd byte and overrun bytes dropped
    set_hdr(8'h80, 8'h00, 16'h0001, 32'h12345678);
    send_run(1'b0, 21, 16'd17);
    check_eq("t4_odd_level", lvl_a, 488);
    check_eq("t4_odd_ok", ok_a, 6);
    check_eq("t4_odd_gap", gap_a, 2);

    // Small FIFO: buffering read, overflow then drain to underflow
    pulse_rden(1'b1);
    check_eq("t5_buf_out", out_b, 0);
    check_eq("t5_buf_unf", unf_b, 0);
    set_hdr(8'h80, 8'h00, 16'h0100, 32'h12345678);
    for (int k = 0; k < 20; k++) begin
      pkt[12 + 2*k] = 8'h30 + 8'(k);
      pkt[13 + 2*k] = 8'hC0 + 8'(k);
      if (k < 16) exp_q.push_back({8'h30 + 8'(k), 8'hC0 + 8'(k)});
    end
    send_run(1'b1, 52, 16'd52);
    check_eq("t5_ovf", ovf_b, 4);
    check_eq("t5_level", lvl_b, 16);
    check_eq("t5_play", play_b, 1);
    check_eq("t5_ok", ok_b, 1);
    for (int k = 0; k < 16; k++) begin
      pulse_rden(1'b1);
      check_eq($sformatf("t5_rd%0d", k), out_b, exp_q.pop_front());
    end
    pulse_rden(1'b1);
    check_eq("t5_unf_out", out_b, 0);
    check_eq("t5_unf", unf_b, 1);
    @(negedge clk);
    check_eq("t5_unf_play", play_b, 0);
    check_eq("t5_unf_level", lvl_b, 0);

    // Reset mid-packet at bc=100 with valid held high
    set_hdr(8'h80, 8'h00, 16'd7, 32'h12345678);
    for (int i = 0; i < 972; i++) begin
      @(negedge clk);
      valid_a = 1'b1;
      rdata   = pkt[i];
      length  = 16'd972;
      rst     = (i == 100);
    end
    @(negedge clk);
    valid_a = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    check_eq("t6_ok", ok_a, 0);
    check_eq("t6_err", err_a, 0);
    check_eq("t6_level", lvl_a, 0);
    check_eq("t6_play", play_a, 0);
    check_eq("t6_seq_gap", {seq_a, gap_a}, 0);
    check_eq("t6_b_ovf", ovf_b, 0);
    send_run(1'b0, 972, 16'd972);
    check_eq("t6_next_ok", ok_a, 1);
    check_eq("t6_next_seq", seq_a, 7);
    check_eq("t6_next_gap", gap_a, 0);
    check_eq("t6_next_level", lvl_a, 480);
    check_eq("t6_next_play", play_a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
